// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the block-RAM stream reader and its
// two-entry output buffer.
package bram_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  // A new read may be issued only if the word it returns is guaranteed a slot:
  // buffered words plus the read already in flight, minus this cycle's pop.
  function automatic logic has_credit(
    input logic [FIFO_CNT_W-1:0] fifo_count,
    input logic                  inflight,
    input logic                  pop
  );
    return (int'(fifo_count) + int'(inflight)) < (FIFO_DEPTH + int'(pop));
  endfunction

endpackage

// File: rtl/bram_stream_fifo2.sv
// Two-entry synchronous FIFO holding {last, data}; head is presented
// combinationally and stays stable until popped.
module bram_stream_fifo2
  import bram_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH:0]        push_data,
  input  logic                  pop,
  output logic [WIDTH:0]        head,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH:0]        mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [FIFO_CNT_W-1:0] count_reg;
  logic [FIFO_DEPTH-1:0] wr_en;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_reg == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  // When full, a simultaneous pop frees the head slot that the write lands in.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= push_data;
        end
      end
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + FIFO_CNT_W'(1);
        2'b01:   count_reg <= count_reg - FIFO_CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a contiguous RAM address range and streams each word out on a
// valid/ready interface, hiding the one-cycle registered read latency.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   base_addr,
  input  logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  input  logic [WIDTH-1:0]           mem_data,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_t                state_reg;
  state_t                state_next;
  logic [AW-1:0]         addr_reg;
  logic [AW-1:0]         addr_next;
  logic [CW-1:0]         remaining_reg;
  logic [CW-1:0]         remaining_next;
  logic                  inflight_reg;
  logic                  inflight_last_reg;
  logic                  done_reg;
  logic                  done_next;

  logic                  accept;
  logic                  pop;
  logic                  last_pop;
  logic                  issue;
  logic [WIDTH:0]        fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;

  assign accept   = (state_reg == IDLE) && start;
  assign pop      = out_valid && out_ready;
  assign last_pop = pop && out_last;

  assign mem_addr  = addr_reg;
  assign done      = done_reg;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[WIDTH-1:0];
  assign out_last  = fifo_head[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && (count != '0)) state_next = RUN;
      RUN:     if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    issue = 1'b0;
    if (state_reg == RUN) begin
      busy  = 1'b1;
      issue = (remaining_reg != '0) && (!fifo_full || pop)
              && has_credit(fifo_count, inflight_reg, pop);
    end
  end

  always_comb begin
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    if (accept && (count != '0)) begin
      addr_next      = base_addr;
      remaining_next = count;
    end else if (issue) begin
      addr_next      = (addr_reg == AW'(DEPTH - 1)) ? '0 : addr_reg + AW'(1);
      remaining_next = remaining_reg - CW'(1);
    end
    // An empty command completes immediately; otherwise completion follows the tagged final beat.
    done_next = (accept && (count == '0)) || ((state_reg == RUN) && last_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg          <= '0;
      remaining_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      addr_reg          <= addr_next;
      remaining_reg     <= remaining_next;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (remaining_reg == CW'(1));
      done_reg          <= done_next;
    end
  end

  // The RAM answers one cycle after the address, so capture is keyed off the in-flight flag.
  bram_stream_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data ({inflight_last_reg, mem_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
